// File: rtl/ring_nic.sv
// PE-side network interface between a processor register port and a ring router PE port.
// One injection buffer (offered only on the polarity matching its VC bit) and one ejection buffer.
module ring_nic #(
  parameter int DATA_W = 64,
  parameter int VC_BIT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nic_en,
  input  logic              nic_wr_en,
  input  logic              net_polarity,
  output logic              net_so,
  input  logic              net_ri,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_si,
  output logic              net_ro,
  input  logic [DATA_W-1:0] net_di
);

  typedef enum logic {TX_EMPTY = 1'b0, TX_LOADED = 1'b1} tx_state_t;
  typedef enum logic {RX_EMPTY = 1'b0, RX_FULL = 1'b1} rx_state_t;

  tx_state_t         tx_state_reg, tx_state_next;
  rx_state_t         rx_state_reg, rx_state_next;
  logic [DATA_W-1:0] out_buf_reg, out_buf_next;
  logic [DATA_W-1:0] in_buf_reg, in_buf_next;

  logic out_full, in_full;
  logic wr_out_buf, rd_in_buf;

  assign out_full   = (tx_state_reg == TX_LOADED);
  assign in_full    = (rx_state_reg == RX_FULL);
  assign wr_out_buf = nic_en & nic_wr_en & (addr == 2'd2);
  assign rd_in_buf  = nic_en & ~nic_wr_en & (addr == 2'd0);

  assign net_so = out_full & (net_polarity == out_buf_reg[VC_BIT]);
  assign net_do = out_buf_reg;
  assign net_ro = ~in_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg <= TX_EMPTY;
      rx_state_reg <= RX_EMPTY;
      out_buf_reg  <= '0;
      in_buf_reg   <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      rx_state_reg <= rx_state_next;
      out_buf_reg  <= out_buf_next;
      in_buf_reg   <= in_buf_next;
    end
  end

  // A write while loaded is dropped, even if the packet leaves on that same edge.
  always_comb begin
    tx_state_next = tx_state_reg;
    out_buf_next  = out_buf_reg;
    case (tx_state_reg)
      TX_EMPTY: begin
        if (wr_out_buf) begin
          tx_state_next = TX_LOADED;
          out_buf_next  = d_in;
        end
      end
      TX_LOADED: begin
        if (net_so && net_ri) tx_state_next = TX_EMPTY;
      end
      default: tx_state_next = TX_EMPTY;
    endcase
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    in_buf_next   = in_buf_reg;
    case (rx_state_reg)
      RX_EMPTY: begin
        if (net_si) begin
          rx_state_next = RX_FULL;
          in_buf_next   = net_di;
        end
      end
      RX_FULL: begin
        if (rd_in_buf) rx_state_next = RX_EMPTY;
      end
      default: rx_state_next = RX_EMPTY;
    endcase
  end

  always_comb begin
    d_out = '0;
    if (nic_en && !nic_wr_en) begin
      case (addr)
        2'd0:    d_out = in_buf_reg;
        2'd1:    d_out = {{(DATA_W-1){1'b0}}, in_full};
        2'd3:    d_out = {{(DATA_W-1){1'b0}}, out_full};
        default: d_out = '0;
      endcase
    end
  end

endmodule
